mem_port_arbiter: RTL and testbench

Sequences the single-port unified memory shared by instruction fetch (PCF) and data access (ALUResultM/WriteDataM/MemWriteM) of the 5-stage pipeline. It serves at most one memory transaction at a time and registers the returned data for the requester. It raises `pipe_stall` until every active requester of the current pipeline cycle has been served; top-level glue drives StallF/StallD and holds E/M/W from this signal. Data access has priority over fetch.

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/sat_counter.sv | 23 ++
 rtl/mem_port_arbiter.sv | 114 +++++++++++
 tb/tb_mem_port_arbiter.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory port arbiter: FSM state and transaction owner.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT_R = 2'd2
    } arbState_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_t;

    localparam int STALL_CNT_W = 32;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with increment enable; sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

    assign count = cnt;

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises fetch and data accesses onto one memory port, one transaction at a time,
// and stalls the pipeline until every active requester of the current cycle is served.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_served,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_served,
    output logic              pipe_stall,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [31:0]       stall_cycles
);

    arbState_t state;
    owner_t    owner;
    logic      ifPend;
    logic      dmPend;

    assign ifPend     = if_req & ~if_served;
    assign dmPend     = dm_req & ~dm_served;
    assign pipe_stall = ifPend | dmPend;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state     <= IDLE;
            owner     <= OWN_IF;
            mem_valid <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
            if_served <= 1'b0;
            dm_served <= 1'b0;
        end else begin
            // Pipeline advances at this edge; a served flag set below still wins.
            if (!pipe_stall) begin
                if_served <= 1'b0;
                dm_served <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (pipe_stall) begin
                        if (dmPend) begin
                            owner     <= OWN_DM;
                            mem_we    <= dm_we;
                            mem_addr  <= dm_addr;
                            mem_wdata <= dm_wdata;
                            mem_valid <= 1'b1;
                            state     <= ISSUE;
                        end else begin
                            owner     <= OWN_IF;
                            mem_we    <= 1'b0;
                            mem_addr  <= if_addr;
                            mem_wdata <= '0;
                            mem_valid <= 1'b1;
                            state     <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (mem_ready) begin
                        mem_valid <= 1'b0;
                        if (mem_we) begin
                            dm_served <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            state <= WAIT_R;
                        end
                    end
                end
                WAIT_R: begin
                    if (mem_rvalid) begin
                        if (owner == OWN_DM) begin
                            dm_rdata  <= mem_rdata;
                            dm_served <= 1'b1;
                        end else begin
                            if_rdata  <= mem_rdata;
                            if_served <= 1'b1;
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    sat_counter #(.W(STALL_CNT_W)) uStallCnt (
        .clk   (clk),
        .clr_n (clr_n),
        .inc   (pipe_stall),
        .count (stall_cycles)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs change and outputs are checked on the falling edge.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        clr_n = 1'b0;
    logic        if_req, dm_req, dm_we;
    logic [31:0] if_addr, dm_addr, dm_wdata;
    logic [31:0] if_rdata, dm_rdata;
    logic        if_served, dm_served, pipe_stall;
    logic        mem_valid, mem_ready, mem_we, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [31:0] stall_cycles;

    int nCmp = 0;
    int nErr = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk          (clk),
        .clr_n        (clr_n),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_rdata     (if_rdata),
        .if_served    (if_served),
        .dm_req       (dm_req),
        .dm_we        (dm_we),
        .dm_addr      (dm_addr),
        .dm_wdata     (dm_wdata),
        .dm_rdata     (dm_rdata),
        .dm_served    (dm_served),
        .pipe_stall   (pipe_stall),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata),
        .stall_cycles (stall_cycles)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCmp++;
        if (obs !== exp) begin
            nErr++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic clrInputs();
        if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0;
        mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
    endtask

    task automatic doReset();
        nxt(); clr_n = 0;
        nxt(); clr_n = 1;
    endtask

    initial begin
        clrInputs();
        // Fetch out of reset, then a back-to-back fetch at PC+4
        if_req = 1; mem_ready = 1;
        nxt();
        chk("rst_valid",  32'(mem_valid),  32'd0);
        chk("rst_served", 32'(if_served),  32'd0);
        chk("rst_addr",   mem_addr,        32'h0);
        chk("rst_rdata",  if_rdata,        32'h0);
        chk("rst_cnt",    stall_cycles,    32'd0);
        chk("rst_stall",  32'(pipe_stall), 32'd1);
        clr_n = 1;
        nxt();
        chk("f0_valid", 32'(mem_valid), 32'd1);
        chk("f0_addr",  mem_addr,       32'h0);
        nxt();
        chk("f0_accept", 32'(mem_valid), 32'd0);
        mem_rvalid = 1; mem_rdata = 32'h0050_0093;
        nxt();
        mem_rvalid = 0;
        chk("f0_served", 32'(if_served),  32'd1);
        chk("f0_rdata",  if_rdata,        32'h0050_0093);
        chk("f0_stall",  32'(pipe_stall), 32'd0);
        chk("f0_cnt",    stall_cycles,    32'd3);
        if_addr = 32'h4;
        nxt();
        chk("f1_clear",  32'(if_served),  32'd0);
        chk("f1_stall",  32'(pipe_stall), 32'd1);
        chk("f1_nodup",  32'(mem_valid),  32'd0);
        nxt();
        chk("f1_valid", 32'(mem_valid), 32'd1);
        chk("f1_addr",  mem_addr,       32'h4);
        nxt();
        mem_rvalid = 1; mem_rdata = 32'h0010_0113;
        nxt();
        mem_rvalid = 0;
        chk("f1_served", 32'(if_served), 32'd1);
        chk("f1_rdata",  if_rdata,       32'h0010_0113);
        if_req = 0;
        nxt();
        chk("idle_stall", 32'(pipe_stall), 32'd0);
        chk("idle_valid", 32'(mem_valid),  32'd0);

        // Load and fetch together: data first, then fetch
        clrInputs(); doReset();
        if_req = 1; if_addr = 32'h200; dm_req = 1; dm_addr = 32'h100; mem_ready = 1;
        nxt();
        chk("lf_d_valid", 32'(mem_valid), 32'd1);
        chk("lf_d_addr",  mem_addr,       32'h100);
        chk("lf_d_we",    32'(mem_we),    32'd0);
        nxt();
        mem_rvalid = 1; mem_rdata = 32'hA5A5_0001;
        nxt();
        mem_rvalid = 0;
        chk("lf_d_served", 32'(dm_served),  32'd1);
        chk("lf_d_rdata",  dm_rdata,        32'hA5A5_0001);
        chk("lf_mid_stall",32'(pipe_stall), 32'd1);
        nxt();
        chk("lf_f_valid", 32'(mem_valid), 32'd1);
        chk("lf_f_addr",  mem_addr,       32'h200);
        nxt();
        mem_rvalid = 1; mem_rdata = 32'h0000_0013;
        nxt();
        mem_rvalid = 0;
        chk("lf_f_served", 32'(if_served),  32'd1);
        chk("lf_f_rdata",  if_rdata,        32'h0000_0013);
        chk("lf_d_hold",   32'(dm_served),  32'd1);
        chk("lf_stall",    32'(pipe_stall), 32'd0);
        chk("lf_cnt",      stall_cycles,    32'd6);
        if_req = 0; dm_req = 0;

        // Store with three not-ready cycles
        clrInputs(); doReset();
        dm_req = 1; dm_we = 1; dm_addr = 32'h40; dm_wdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 4; i++) begin
            nxt();
            chk($sformatf("st_valid%0d", i), 32'(mem_valid), 32'd1);
            chk($sformatf("st_we%0d", i),    32'(mem_we),    32'd1);
            chk($sformatf("st_addr%0d", i),  mem_addr,       32'h40);
            chk($sformatf("st_wdata%0d", i), mem_wdata,      32'hDEAD_BEEF);
            chk($sformatf("st_early%0d", i), 32'(dm_served), 32'd0);
        end
        mem_ready = 1;
        nxt();
        chk("st_served", 32'(dm_served),  32'd1);
        chk("st_idle",   32'(mem_valid),  32'd0);
        chk("st_stall",  32'(pipe_stall), 32'd0);
        dm_req = 0; mem_ready = 0;

        // Reset during WAIT_R; late response must be ignored and the fetch reissued
        clrInputs(); doReset();
        if_req = 1; if_addr = 32'h80; mem_ready = 1;
        nxt(); nxt();
        clr_n = 0;
        nxt();
        chk("rw_served0", 32'(if_served), 32'd0);
        chk("rw_valid0",  32'(mem_valid), 32'd0);
        clr_n = 1; mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'h0000_0BAD;
        nxt();
        chk("rw_served1", 32'(if_served), 32'd0);
        chk("rw_reissue", 32'(mem_valid), 32'd1);
        chk("rw_addr",    mem_addr,       32'h80);
        nxt();
        chk("rw_served2", 32'(if_served), 32'd0);
        chk("rw_rdata0",  if_rdata,       32'h0);
        mem_rvalid = 0; mem_ready = 1;
        nxt();
        mem_rvalid = 1; mem_rdata = 32'h0000_1234;
        nxt();
        mem_rvalid = 0;
        chk("rw_served3", 32'(if_served), 32'd1);
        chk("rw_rdata1",  if_rdata,       32'h0000_1234);

        // Stall counter saturation from a near-max preload
        clrInputs(); doReset();
        if_req = 1;
        nxt();
        force dut.uStallCnt.cnt = 32'hFFFF_FFFA;
        nxt();
        release dut.uStallCnt.cnt;
        repeat (5) @(posedge clk);
        nxt();
        chk("sat_reach", stall_cycles, 32'hFFFF_FFFF);
        repeat (5) @(posedge clk);
        nxt();
        chk("sat_hold",  stall_cycles, 32'hFFFF_FFFF);
        chk("sat_stall", 32'(pipe_stall), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
